// File: rtl/square_fill_ctrl_if.sv
// Command handshake from game logic plus the Avalon-MM write port to the pixel buffer.
// The master modport is the fill controller; the slave modport is its environment.
interface square_fill_ctrl_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 16
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_color;

    logic [31:0]        m_address;
    logic               m_write;
    logic [COLOR_W-1:0] m_writedata;
    logic               m_waitrequest;

    modport master (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, m_waitrequest,
        output cmd_ready, m_address, m_write, m_writedata
    );

    modport slave (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, m_waitrequest,
        input  cmd_ready, m_address, m_write, m_writedata
    );
endinterface

// File: rtl/square_fill_ctrl.sv
// Turns rectangle-fill commands into one pixel-buffer write per visible pixel,
// walking the rectangle row-major and skipping pixels that fall off screen.
module square_fill_ctrl #(
    parameter int          X_W       = 9,
    parameter int          Y_W       = 8,
    parameter int          SCREEN_W  = 320,
    parameter int          SCREEN_H  = 240,
    parameter int          COLOR_W   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    square_fill_ctrl_if.master bus,
    output logic               busy,
    output logic               done
);

    // One extra bit on the cursor so x0+w-1 / y0+h-1 never wrap.
    localparam int XC_W = X_W + 1;
    localparam int YC_W = Y_W + 1;
    localparam logic [XC_W-1:0] SCR_W_C = XC_W'(SCREEN_W);
    localparam logic [YC_W-1:0] SCR_H_C = YC_W'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t             state_q;
    logic [X_W-1:0]     x0_q;
    logic [Y_W-1:0]     y0_q;
    logic [X_W-1:0]     w_q;
    logic [Y_W-1:0]     h_q;
    logic [XC_W-1:0]    cx_q;
    logic [YC_W-1:0]    cy_q;
    logic               m_write_q;
    logic [31:0]        m_address_q;
    logic [COLOR_W-1:0] m_writedata_q;
    logic               busy_q;
    logic               done_q;
    logic               cmd_ready_q;

    logic [XC_W-1:0]    last_x;
    logic [YC_W-1:0]    last_y;
    logic               last_col;
    logic               last_row;
    logic [XC_W-1:0]    cx_d;
    logic [YC_W-1:0]    cy_d;
    logic               advance;
    logic [XC_W-1:0]    cmd_cx;
    logic [YC_W-1:0]    cmd_cy;

    function automatic logic pix_visible(input logic [XC_W-1:0] x, input logic [YC_W-1:0] y);
        return (x < SCR_W_C) && (y < SCR_H_C);
    endfunction

    function automatic logic [31:0] pix_addr(input logic [XC_W-1:0] x, input logic [YC_W-1:0] y);
        return BASE_ADDR + (32'(y) << XC_W) + (32'(x) << 1);
    endfunction

    always_comb begin
        cmd_cx   = XC_W'(bus.cmd_x);
        cmd_cy   = YC_W'(bus.cmd_y);
        last_x   = XC_W'(x0_q) + XC_W'(w_q) - XC_W'(1);
        last_y   = YC_W'(y0_q) + YC_W'(h_q) - YC_W'(1);
        last_col = (cx_q == last_x);
        last_row = (cy_q == last_y);
        cx_d     = last_col ? XC_W'(x0_q) : cx_q + XC_W'(1);
        cy_d     = last_col ? cy_q + YC_W'(1) : cy_q;
        // A visible pixel waits for the slave; a clipped one takes a single cycle.
        advance  = !m_write_q || !bus.m_waitrequest;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            x0_q          <= '0;
            y0_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        x0_q          <= bus.cmd_x;
                        y0_q          <= bus.cmd_y;
                        w_q           <= bus.cmd_w;
                        h_q           <= bus.cmd_h;
                        cx_q          <= cmd_cx;
                        cy_q          <= cmd_cy;
                        m_writedata_q <= bus.cmd_color;
                        cmd_ready_q   <= 1'b0;
                        if (bus.cmd_w == '0 || bus.cmd_h == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Present the first pixel right away so it lands in the next cycle.
                            state_q     <= DRAW;
                            busy_q      <= 1'b1;
                            m_write_q   <= pix_visible(cmd_cx, cmd_cy);
                            m_address_q <= pix_addr(cmd_cx, cmd_cy);
                        end
                    end
                end
                DRAW: begin
                    if (advance) begin
                        if (last_col && last_row) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            m_write_q <= 1'b0;
                        end else begin
                            cx_q        <= cx_d;
                            cy_q        <= cy_d;
                            m_write_q   <= pix_visible(cx_d, cy_d);
                            m_address_q <= pix_addr(cx_d, cy_d);
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    m_write_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.m_write     = m_write_q;
    assign bus.m_address   = m_address_q;
    assign bus.m_writedata = m_writedata_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_square_fill_ctrl.sv
// Directed bench for square_fill_ctrl: fills, stalls, clipping, zero size,
// back-to-back commands and reset in the middle of a stalled write.
module tb_square_fill_ctrl;

    logic clk_clk;
    logic reset_reset_n;
    logic busy;
    logic done;

    int errors = 0;
    int checks = 0;
    int dcnt   = 0;
    logic [31:0] wq[$];

    square_fill_ctrl_if #(.X_W(9), .Y_W(8), .COLOR_W(16)) bus ();

    square_fill_ctrl #(
        .X_W(9), .Y_W(8), .SCREEN_W(320), .SCREEN_H(240),
        .COLOR_W(16), .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus),
        .busy          (busy),
        .done          (done)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Log every accepted write and every done pulse.
    always @(posedge clk_clk) begin
        if (reset_reset_n === 1'b1 && bus.m_write === 1'b1 && bus.m_waitrequest === 1'b0)
            wq.push_back(bus.m_address);
        if (reset_reset_n === 1'b1 && done === 1'b1)
            dcnt++;
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input logic [31:0] exp [4], input int n);
        logic [31:0] got;
        check({tag, "_nwr"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
            check($sformatf("%s_wr%0d", tag, i), got, exp[i]);
        end
    endtask

    task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                        input logic [7:0] h, input logic [15:0] color);
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        reset_reset_n     = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_x         = '0;
        bus.cmd_y         = '0;
        bus.cmd_w         = '0;
        bus.cmd_h         = '0;
        bus.cmd_color     = '0;
        bus.m_waitrequest = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_write", 32'(bus.m_write), 32'd0);
        check("rst_addr", bus.m_address, 32'd0);
        check("rst_data", 32'(bus.m_writedata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_reset_n = 1'b1;
        tick();

        // Basic 2x2 fill at (2,3): rows are 1024 bytes apart, pixels 2 bytes.
        wq.delete(); dcnt = 0;
        send(9'd2, 8'd3, 9'd2, 8'd2, 16'hF800);
        check("t1_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t1_w0", 32'(bus.m_write), 32'd1);
        check("t1_a0", bus.m_address, 32'h0000_0C04);
        check("t1_d0", 32'(bus.m_writedata), 32'h0000_F800);
        check("t1_busy0", 32'(busy), 32'd1);
        check("t1_rdy0", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("t1_a1", bus.m_address, 32'h0000_0C06);
        tick();
        check("t1_a2", bus.m_address, 32'h0000_1004);
        check("t1_busy2", 32'(busy), 32'd1);
        tick();
        check("t1_a3", bus.m_address, 32'h0000_1006);
        check("t1_w3", 32'(bus.m_write), 32'd1);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_wr_off", 32'(bus.m_write), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_rdy_done", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_rdy_back", 32'(bus.cmd_ready), 32'd1);
        check_writes("t1", '{32'h0C04, 32'h0C06, 32'h1004, 32'h1006}, 4);
        check("t1_dcnt", 32'(dcnt), 32'd1);

        // Same fill with the slave stalling three cycles on the second pixel.
        wq.delete(); dcnt = 0;
        send(9'd2, 8'd3, 9'd2, 8'd2, 16'hF800);
        tick();
        bus.cmd_valid = 1'b0;
        check("t2_a0", bus.m_address, 32'h0000_0C04);
        tick();
        bus.m_waitrequest = 1'b1;
        check("t2_a1_s0", bus.m_address, 32'h0000_0C06);
        tick();
        check("t2_a1_s1", bus.m_address, 32'h0000_0C06);
        check("t2_w_s1", 32'(bus.m_write), 32'd1);
        check("t2_d_s1", 32'(bus.m_writedata), 32'h0000_F800);
        tick();
        check("t2_a1_s2", bus.m_address, 32'h0000_0C06);
        check("t2_w_s2", 32'(bus.m_write), 32'd1);
        tick();
        bus.m_waitrequest = 1'b0;
        check("t2_a1_go", bus.m_address, 32'h0000_0C06);
        check("t2_w_go", 32'(bus.m_write), 32'd1);
        tick();
        check("t2_a2", bus.m_address, 32'h0000_1004);
        tick();
        check("t2_a3", bus.m_address, 32'h0000_1006);
        tick();
        check("t2_done", 32'(done), 32'd1);
        tick();
        check_writes("t2", '{32'h0C04, 32'h0C06, 32'h1004, 32'h1006}, 4);
        check("t2_dcnt", 32'(dcnt), 32'd1);

        // Rectangle hanging off the bottom-right corner: only (318,239) and (319,239) land.
        wq.delete(); dcnt = 0;
        send(9'd318, 8'd239, 9'd4, 8'd2, 16'h07E0);
        tick();
        bus.cmd_valid = 1'b0;
        wait_done("t3_done", 30);
        tick();
        check("t3_rdy", 32'(bus.cmd_ready), 32'd1);
        check_writes("t3", '{32'h0003_BE7C, 32'h0003_BE7E, 32'h0, 32'h0}, 2);
        check("t3_dcnt", 32'(dcnt), 32'd1);

        // Zero width: done in T+1, ready in T+2, no writes.
        wq.delete(); dcnt = 0;
        send(9'd5, 8'd5, 9'd0, 8'd5, 16'hFFFF);
        tick();
        bus.cmd_valid = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_wr", 32'(bus.m_write), 32'd0);
        check("t4_rdy_lo", 32'(bus.cmd_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        tick();
        check("t4_rdy_hi", 32'(bus.cmd_ready), 32'd1);
        check("t4_done_off", 32'(done), 32'd0);
        check("t4_nwr", 32'(wq.size()), 32'd0);

        // Back-to-back: valid held high, second command waits for ready after done.
        wq.delete(); dcnt = 0;
        send(9'd0, 8'd0, 9'd1, 8'd1, 16'h07E0);
        tick();
        send(9'd5, 8'd1, 9'd1, 8'd1, 16'h001F);
        check("t5_a0", bus.m_address, 32'h0000_0000);
        check("t5_d0", 32'(bus.m_writedata), 32'h0000_07E0);
        check("t5_w0", 32'(bus.m_write), 32'd1);
        tick();
        check("t5_done_a", 32'(done), 32'd1);
        check("t5_rdy_a", 32'(bus.cmd_ready), 32'd0);
        check("t5_wr_gap", 32'(bus.m_write), 32'd0);
        tick();
        check("t5_rdy_b", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t5_w1", 32'(bus.m_write), 32'd1);
        check("t5_a1", bus.m_address, 32'h0000_040A);
        check("t5_d1", 32'(bus.m_writedata), 32'h0000_001F);
        tick();
        check("t5_done_b", 32'(done), 32'd1);
        tick();
        check_writes("t5", '{32'h0000, 32'h040A, 32'h0, 32'h0}, 2);
        check("t5_dcnt", 32'(dcnt), 32'd2);

        // Reset while a write is stalled: write drops at once, no done pulse.
        wq.delete(); dcnt = 0;
        send(9'd10, 8'd10, 9'd3, 8'd1, 16'h1234);
        tick();
        bus.cmd_valid     = 1'b0;
        bus.m_waitrequest = 1'b1;
        check("t6_a0", bus.m_address, 32'h0000_2814);
        tick();
        check("t6_w_stall", 32'(bus.m_write), 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("t6_wr_async", 32'(bus.m_write), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_rdy_async", 32'(bus.cmd_ready), 32'd1);
        tick();
        tick();
        bus.m_waitrequest = 1'b0;
        reset_reset_n     = 1'b1;
        tick();
        tick();
        check("t6_rdy", 32'(bus.cmd_ready), 32'd1);
        check("t6_wr", 32'(bus.m_write), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_dcnt", 32'(dcnt), 32'd0);
        check("t6_nwr", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
